cbus_mmu_arbiter: RTL and testbench
===================================

Name: cbus_mmu_arbiter

Overview:
- Arbitrates between several MMU-side cbus masters and drives the single cbus port to the memory/cache system. Typical masters: I-side MMU, D-side MMU, page-walker.
- Sits directly downstream of each MMU's physical-address output (oreq/oresp).
- Grants one master at a time and holds the grant for the whole transaction, including multi-beat bursts, until the final beat completes (ready && last).
- Supports round-robin or fixed-priority selection.

Parameters:
- NUM_PORTS, 2: number of upstream masters (2..8).
- FIXED_PRIO, 0: 0 = round-robin; 1 = fixed priority, port 0 highest.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset).
- ireqs  input  cbus_req_t[NUM_PORTS]  requests from upstream MMUs.
- iresps  output  cbus_resp_t[NUM_PORTS]  responses to upstream MMUs.
- oreq  output  cbus_req_t  request to the downstream memory bus.
- oresp  input  cbus_resp_t  response from the downstream memory bus.
- grant_valid  output  1  a transaction is currently granted.
- grant_idx  output  $clog2(NUM_PORTS)  index of the granted port; valid only when grant_valid=1.

Behaviour:
- Clock and reset: one clock domain. reset=0 asynchronously forces the following state immediately, regardless of clk:
  - state=ARB_IDLE, grant_valid=0, grant_idx=0, rr_ptr=0;
  - oreq='0 and all iresps='0, because both are decoded from state.
- State ARB_IDLE:
  - oreq='0 and all iresps='0.
  - If any ireqs[i].valid=1, a winner is chosen combinationally.
  - Round-robin (FIXED_PRIO=0): winner is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
  - Fixed priority (FIXED_PRIO=1): winner is the lowest valid index.
  - At the next edge: grant_idx <= winner, grant_valid <= 1, state <= ARB_BUSY.
  - If no port is valid, the state holds.
- State ARB_BUSY:
  - oreq = ireqs[grant_idx] forwarded live and unmodified.
  - iresps[grant_idx] = oresp.
  - All other iresps='0. Non-granted masters see ready=0 and stall.
- Completion: oresp.ready && oresp.last in ARB_BUSY. At that edge:
  - state <= ARB_IDLE, grant_valid <= 0;
  - rr_ptr <= (grant_idx+1) mod NUM_PORTS.
  - Non-last beats (ready=1, last=0) keep the grant. Bursts of any len stay locked to one master.
- Abort: granted master's valid=0 while in ARB_BUSY, with no ready&&last in the same cycle.
  - oreq.valid=0 that cycle.
  - At the next edge: state <= ARB_IDLE, grant_valid <= 0, rr_ptr unchanged.
- Latency and bubbles:
  - Request valid to oreq.valid is 1 cycle (registered grant).
  - There is one idle bubble cycle after every completion or abort, before the next grant.
- Simultaneous events:
  - A request arriving in the completion cycle is not considered until ARB_IDLE.
  - A completion in the same cycle as a valid drop counts as completion, so rr_ptr advances.
- Reset asserted mid-burst: the grant is dropped asynchronously and oreq.valid goes to 0 immediately. The downstream bus must tolerate this (same as a cbus reset).
- Width rules:
  - grant_idx and rr_ptr are $clog2(NUM_PORTS) bits; modulo wrap is explicit for non-power-of-2 NUM_PORTS.
  - Unused encodings (e.g. 3 when NUM_PORTS=3) are never produced.
- No request buffering: every ireq field, including data, strobe, addr and len, passes through combinationally from the granted port.

Test Plan:
- Single request: port1 read addr=0x8000_1000, len=0; oresp ready/last at cycle 3.
  - oreq.valid rises 1 cycle after the request; iresps[1].ready/last=1 with data 0xDEAD_BEEF_0000_0001 in the same cycle; iresps[0]='0; grant_valid falls the next cycle.
- Contention, round-robin: ports 0 and 1 both valid from reset.
  - Port 0 granted first. After its last beat: one bubble cycle, then grant_idx=1. After port 1 completes, port 0 is granted again.
- Burst lock: port0 len=3, 4 beats with last on beat 4; port1 valid throughout.
  - All 4 beats routed to iresps[0]; iresps[1].ready=0 throughout; grant moves to port1 only after beat 4.
- Fixed priority (FIXED_PRIO=1, NUM_PORTS=3): ports 1 and 2 valid, then port0 becomes valid during port1's transaction.
  - Order of grants: 1, 0, 2.
- Abort: port0 granted, valid drops before any ready.
  - The next edge returns to idle with grant_valid=0 and rr_ptr still 0. A subsequent port0/port1 contention grants port0.
- Reset mid-burst: reset=0 between beats 2 and 3 of a len=3 burst.
  - oreq.valid=0 and grant_valid=0 immediately, without a clock edge. After release, port0 and port1 both valid gives grant_idx=0.

Source files
------------

// File: rtl/cbus_mmu_arbiter.sv
// Arbiter between several MMU-side cbus masters and the single downstream cbus port.
// The grant is held for a whole transaction (including bursts) until ready && last.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strobe;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_mmu_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  cbus_req_t  [NUM_PORTS-1:0]          ireqs,
  output cbus_resp_t [NUM_PORTS-1:0]          iresps,
  output cbus_req_t                           oreq,
  input  cbus_resp_t                          oresp,
  output logic                                grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]        grant_idx
);

  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  grant_idx_nxt;
  logic [IW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]  winner;
  logic           any_valid;

  // Candidate order starts at rr_ptr (or 0 for fixed priority); explicit wrap
  // keeps non-power-of-2 port counts from producing unused encodings.
  always_comb begin
    int unsigned cand;
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      cand = o;
      if (!FIXED_PRIO) cand = cand + 32'(rr_ptr);
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!any_valid && ireqs[cand[IW-1:0]].valid) begin
        winner    = cand[IW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    unique case (state)
      ARB_IDLE: begin
        if (any_valid) begin
          state_nxt     = ARB_BUSY;
          grant_idx_nxt = winner;
        end
      end
      ARB_BUSY: begin
        // Completion wins over a same-cycle valid drop, so the pointer still advances.
        if (oresp.ready && oresp.last) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (!ireqs[grant_idx].valid) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    oreq        = '0;
    iresps      = '0;
    grant_valid = 1'b0;
    if (state == ARB_BUSY) begin
      grant_valid       = 1'b1;
      oreq              = ireqs[grant_idx];
      iresps[grant_idx] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_mmu_arbiter.sv
// Randomized scoreboard bench for cbus_mmu_arbiter: one round-robin and one
// fixed-priority instance, each checked per cycle against a transaction-level model.

module tb_cbus_mmu_arbiter;
  import cbus_pkg::*;

  localparam int NP = 3;
  localparam int GW = $clog2(NP);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_req_t  [NP-1:0] ireqs  [2];
  cbus_resp_t [NP-1:0] iresps [2];
  cbus_req_t           oreq   [2];
  cbus_resp_t          oresp  [2];
  logic                gv     [2];
  logic [GW-1:0]       gidx   [2];

  cbus_mmu_arbiter #(.NUM_PORTS(NP), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset), .ireqs(ireqs[0]), .iresps(iresps[0]),
    .oreq(oreq[0]), .oresp(oresp[0]), .grant_valid(gv[0]), .grant_idx(gidx[0]));

  cbus_mmu_arbiter #(.NUM_PORTS(NP), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset), .ireqs(ireqs[1]), .iresps(iresps[1]),
    .oreq(oreq[1]), .oresp(oresp[1]), .grant_valid(gv[1]), .grant_idx(gidx[1]));

  typedef struct packed {
    logic                gv;
    logic [GW-1:0]       gidx;
    cbus_req_t           oreq;
    cbus_resp_t [NP-1:0] iresps;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which master owns the bus (-1 = none), the round-robin
  // start index, beats seen in the current transaction, and master-side state.
  int        owner [2];
  int        ptr   [2];
  int        beat  [2];
  bit        act   [2][NP];
  cbus_req_t mreq  [2][NP];

  task automatic check(string name, logic [511:0] got, logic [511:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int pick(int k, cbus_req_t [NP-1:0] r);
    for (int o = 0; o < NP; o++) begin
      int i;
      i = (k == 1) ? o : (ptr[k] + o) % NP;
      if (r[i].valid) return i;
    end
    return -1;
  endfunction

  function automatic cbus_req_t rand_req(bit v);
    cbus_req_t r;
    r.valid  = v;
    r.write  = 1'($urandom);
    r.addr   = $urandom;
    r.data   = {$urandom, $urandom};
    r.strobe = 8'($urandom);
    r.len    = 8'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic cmp_inst(int k, exp_t e);
    check($sformatf("i%0d grant_valid", k), 512'(gv[k]), 512'(e.gv));
    if (e.gv) check($sformatf("i%0d grant_idx", k), 512'(gidx[k]), 512'(e.gidx));
    check($sformatf("i%0d oreq", k), 512'(oreq[k]), 512'(e.oreq));
    check($sformatf("i%0d iresps", k), 512'(iresps[k]), 512'(e.iresps));
  endtask

  // Monitor: every cycle the DUTs present outputs, pop the prediction and compare.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) cmp_inst(0, q0.pop_front());
      if (q1.size() > 0) cmp_inst(1, q1.pop_front());
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      ptr[k]   = 0;
      beat[k]  = 0;
      oresp[k] = '0;
      for (int i = 0; i < NP; i++) begin
        act[k][i]   = 1'b0;
        mreq[k][i]  = '0;
        ireqs[k][i] = '0;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    int   w;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) begin
        if (!act[k][i] && $urandom_range(0, 3) == 0) begin
          act[k][i]  = 1'b1;
          mreq[k][i] = rand_req(1'b1);
        end else if (act[k][i] && $urandom_range(0, 39) == 0) begin
          act[k][i] = 1'b0;
        end
        ireqs[k][i] = act[k][i] ? mreq[k][i] : rand_req(1'b0);
      end
      if (owner[k] >= 0 && ireqs[k][owner[k]].valid) begin
        oresp[k].ready = 1'($urandom);
        oresp[k].last  = oresp[k].ready && (beat[k] == int'(mreq[k][owner[k]].len));
      end else begin
        oresp[k].ready = ($urandom_range(0, 7) == 0);
        oresp[k].last  = 1'($urandom);
      end
      oresp[k].data = {$urandom, $urandom};
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e = '0;
      if (owner[k] >= 0) begin
        e.gv               = 1'b1;
        e.gidx             = GW'(owner[k]);
        e.oreq             = ireqs[k][owner[k]];
        e.iresps[owner[k]] = oresp[k];
      end
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      // Advance the model across the coming clock edge.
      if (owner[k] >= 0) begin
        if (oresp[k].ready) beat[k]++;
        if (oresp[k].ready && oresp[k].last) begin
          act[k][owner[k]] = 1'b0;
          ptr[k]   = (owner[k] + 1) % NP;
          owner[k] = -1;
          beat[k]  = 0;
        end else if (!ireqs[k][owner[k]].valid) begin
          owner[k] = -1;
          beat[k]  = 0;
        end
      end else begin
        w = pick(k, ireqs[k]);
        if (w >= 0) begin
          owner[k] = w;
          beat[k]  = 0;
        end
      end
    end
  endtask

  task automatic check_idle(string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s i%0d grant_valid", tag, k), 512'(gv[k]), 512'(0));
      check($sformatf("%s i%0d oreq_valid", tag, k), 512'(oreq[k].valid), 512'(0));
      check($sformatf("%s i%0d iresps", tag, k), 512'(iresps[k]), 512'(0));
    end
  endtask

  task automatic contend_01();
    for (int k = 0; k < 2; k++) begin
      act[k][0]  = 1'b1;
      mreq[k][0] = rand_req(1'b1);
      act[k][1]  = 1'b1;
      mreq[k][1] = rand_req(1'b1);
    end
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("reset");
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset i%0d grant_idx", k), 512'(gidx[k]), 512'(0));
      check($sformatf("reset i%0d oreq", k), 512'(oreq[k]), 512'(0));
    end
    contend_01();
    #1 reset = 1'b1;

    repeat (1500) step();

    // Run on until instance 0 sits between beats 2 and 3 of a len=3 burst.
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(owner[0] >= 0 && beat[0] == 2 && mreq[0][owner[0]].len == 8'd3 &&
                 ireqs[0][owner[0]].valid) && guard < 5000);
    if (guard >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL burst_search: got no mid-burst window expected one within 5000 cycles");
    end else begin
      #2;
      reset = 1'b0;
      #1;
      check_idle("async_reset");
      model_reset();
      repeat (2) @(negedge clk);
      check_idle("held_reset");
      contend_01();
      #1 reset = 1'b1;
    end

    repeat (1500) step();
    repeat (2) @(negedge clk);
    #3;
    check("scoreboard_drain", 512'(q0.size() + q1.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
